clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: cycles a synchronized button level must stay stable before it is accepted.
REQ-002 Parameter LOAD_HOLD_CYCLES, default 100000000: cycles load is held high.
- Spans at least one edge of the 1 Hz time-counter clock.
REQ-003 CLK100MHZ  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_mode  input  1  raw pushbutton, asynchronous, bouncing; advances edit field.
REQ-006 btn_up  input  1  raw pushbutton; increments the field being edited.
REQ-007 btn_down  input  1  raw pushbutton; decrements the field being edited.
REQ-008 cur_hours  input  8  running hours (binary 0-23), seeds the edit.
REQ-009 cur_minutes  input  8  running minutes (binary 0-59), seeds the edit.
REQ-010 cur_seconds  input  8  running seconds (binary 0-59), seeds the edit.
REQ-011 newHours  output  8  edited hours, binary, to the time counter.
REQ-012 newMinutes  output  8  edited minutes, binary.
REQ-013 newSeconds  output  8  edited seconds, binary.
REQ-014 load  output  1  high while the time counter shall take newHours/newMinutes/newSeconds.
REQ-015 mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC.
- Also reads 00 during LOAD.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears the count.
REQ-017 A one-cycle press pulse SHALL fire on each debounced 0->1 transition; holding a button yields exactly one pulse, no auto-repeat.
REQ-018 FSM states SHALL be RUN, SET_HR, SET_MIN, SET_SEC, LOAD; all transitions take effect on the edge after the press pulse.
REQ-019 RUN: mode press -> capture cur_* into newHours/newMinutes/newSeconds, go SET_HR; up/down ignored.
- A captured hour >23 or minute/second >59 SHALL be replaced by 0.
REQ-020 SET_HR: up -> hours+1 with 23 wrapping to 0; down -> hours-1 with 0 wrapping to 23; mode -> SET_MIN.
REQ-021 SET_MIN and SET_SEC: same up/down rules modulo 60 (59->0, 0->59) on their own field; mode in SET_MIN -> SET_SEC; mode in SET_SEC -> LOAD.
REQ-022 Only the field being edited SHALL change; the other two hold.
REQ-023 Up and down pulses in the same cycle SHALL leave the field unchanged.
REQ-024 A mode pulse coinciding with up or down SHALL advance state only; the field is not changed.
REQ-025 LOAD: load=1 starting the first cycle in LOAD, for exactly LOAD_HOLD_CYCLES cycles; newX constant throughout; then -> RUN with load=0.
- All presses during LOAD are ignored.
REQ-026 In RUN, newX SHALL hold the last loaded values; load=0.
REQ-027 The hold counter SHALL be wide enough for LOAD_HOLD_CYCLES and SHALL not wrap.
REQ-028 newX SHALL always stay in range: hours 0-23, minutes/seconds 0-59.

Reset
REQ-029 reset high at a rising edge SHALL force the following on that edge:
- state RUN, mode=00, load=0;
- newHours=newMinutes=newSeconds=0;
- synchronizers, debounced levels and debounce/hold counters to 0.
REQ-030 reset SHALL take priority over all other activity, including mid-edit and mid-LOAD (load drops on the reset edge, no partial hold resumes).
REQ-031 A button held through reset SHALL produce a pulse only after it has been debounced as high following reset.

Verification (DEBOUNCE_CYCLES=4, LOAD_HOLD_CYCLES=8)
REQ-032 Reset: assert reset 2 cycles with buttons toggling -> newX=0, load=0, mode=00.
REQ-033 Bounce: btn_up high 3 cycles, low 1, high 10 in SET_HR from 5 -> exactly one increment, newHours=6.
REQ-034 Full edit from cur=10:20:30:
- mode -> newX 10/20/30, mode=01; up, up -> 12;
- mode -> mode=10; down -> 19;
- mode -> mode=11; mode -> load=1 exactly 8 cycles with 12/19/30, then mode=00.
REQ-035 Wrap: hours 23 + up -> 0; hours 0 + down -> 23; minutes 0 + down -> 59; seconds 59 + up -> 0.
REQ-036 Seeding and collisions:
- cur_hours=30, cur_minutes=75 captured -> 0, 0;
- up+down together -> unchanged;
- mode+up together -> state advances, field unchanged.
REQ-037 Reset mid-LOAD at hold cycle 4 -> load=0 and mode=00 on the reset edge; newX=0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a 24-hour clock. Three raw pushbuttons are
// synchronized and debounced, turned into single press pulses, and used to
// walk an edit FSM through hours, minutes and seconds. After the seconds field
// is confirmed, the edited time is presented with load held high for a fixed
// number of cycles.
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int LOAD_HOLD_CYCLES = 100000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] cur_hours,
  input  logic [7:0] cur_minutes,
  input  logic [7:0] cur_seconds,
  output logic [7:0] newHours,
  output logic [7:0] newMinutes,
  output logic [7:0] newSeconds,
  output logic       load,
  output logic [1:0] mode,
  output logic [2:0] state_dbg
);

  localparam int DW = (DEBOUNCE_CYCLES  > 1) ? $clog2(DEBOUNCE_CYCLES  + 1) : 1;
  localparam int HW = (LOAD_HOLD_CYCLES > 1) ? $clog2(LOAD_HOLD_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_HR   = 3'd1,
    S_MIN  = 3'd2,
    S_SEC  = 3'd3,
    S_LOAD = 3'd4
  } state_t;

  // Bit order for all per-button vectors: [0] mode, [1] up, [2] down.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    db;
  logic [2:0]    db_q;
  logic [DW-1:0] db_cnt [3];
  logic [2:0]    pulse;

  state_t        state;
  logic [HW-1:0] hold_cnt;

  assign btn_raw = {btn_down, btn_up, btn_mode};

  // A press pulse is the first cycle the debounced level reads high.
  assign pulse = db & ~db_q;

  assign state_dbg = state;

  // Wrapping step of a field within 0..max; simultaneous up and down cancel.
  function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] max,
                                      input logic up, input logic dn);
    logic [7:0] r;
    r = v;
    if (up && !dn)      r = (v >= max) ? 8'd0 : v + 8'd1;
    else if (dn && !up) r = (v == 8'd0 || v > max) ? max : v - 8'd1;
    return r;
  endfunction

  // Two-flop synchronizers, mismatch-counting debouncers and edge history.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Edit FSM with registered mode/load and the edited time fields.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state      <= S_RUN;
      mode       <= 2'b00;
      load       <= 1'b0;
      hold_cnt   <= '0;
      newHours   <= 8'd0;
      newMinutes <= 8'd0;
      newSeconds <= 8'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (pulse[0]) begin
            newHours   <= (cur_hours   > 8'd23) ? 8'd0 : cur_hours;
            newMinutes <= (cur_minutes > 8'd59) ? 8'd0 : cur_minutes;
            newSeconds <= (cur_seconds > 8'd59) ? 8'd0 : cur_seconds;
            state      <= S_HR;
            mode       <= 2'b01;
          end
        end
        S_HR: begin
          if (pulse[0]) begin
            state <= S_MIN;
            mode  <= 2'b10;
          end else begin
            newHours <= step(newHours, 8'd23, pulse[1], pulse[2]);
          end
        end
        S_MIN: begin
          if (pulse[0]) begin
            state <= S_SEC;
            mode  <= 2'b11;
          end else begin
            newMinutes <= step(newMinutes, 8'd59, pulse[1], pulse[2]);
          end
        end
        S_SEC: begin
          if (pulse[0]) begin
            state    <= S_LOAD;
            mode     <= 2'b00;
            load     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            newSeconds <= step(newSeconds, 8'd59, pulse[1], pulse[2]);
          end
        end
        S_LOAD: begin
          if (hold_cnt == HW'(LOAD_HOLD_CYCLES - 1)) begin
            state    <= S_RUN;
            load     <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_RUN;
          mode     <= 2'b00;
          load     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with short debounce/hold parameters. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_clock_set_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic [7:0] cur_hours, cur_minutes, cur_seconds;
  logic [7:0] newHours, newMinutes, newSeconds;
  logic       load;
  logic [1:0] mode;
  logic [2:0] state_dbg;

  int vectors;
  int miscompares;

  typedef struct {
    logic       m, u, d;
    logic [7:0] ch, cm, cs;
    logic [7:0] eh, em, es;
    logic [1:0] emode;
  } vec_t;

  vec_t vt[20];

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .LOAD_HOLD_CYCLES(HOLD)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .cur_seconds(cur_seconds),
    .newHours   (newHours),
    .newMinutes (newMinutes),
    .newSeconds (newSeconds),
    .load       (load),
    .mode       (mode),
    .state_dbg  (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int eh, input int em, input int es,
                           input int emode, input int eload);
    check({name, ".hours"},   newHours,   eh);
    check({name, ".minutes"}, newMinutes, em);
    check({name, ".seconds"}, newSeconds, es);
    check({name, ".mode"},    mode,       emode);
    check({name, ".load"},    load,       eload);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Hold the chosen buttons long enough to debounce, then release long enough
  // to debounce the release and let any LOAD phase finish.
  task automatic press(input logic m, input logic u, input logic d);
    btn_mode = m; btn_up = u; btn_down = d;
    tick(8);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(8);
  endtask

  task automatic run_vec(input int i);
    cur_hours = vt[i].ch; cur_minutes = vt[i].cm; cur_seconds = vt[i].cs;
    press(vt[i].m, vt[i].u, vt[i].d);
    check_all($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es, vt[i].emode, 0);
  endtask

  initial begin
    int lcnt;
    int st, h, mi, s;
    logic m, u, d;
    logic [7:0] ch, cm, cs;
    bit got;

    vectors = 0;
    miscompares = 0;

    // Edit from 10:20:30
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30, 2'b01};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 8'd30, 8'd11, 8'd20, 8'd30, 2'b01};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 8'd10, 8'd20, 8'd30, 8'd12, 8'd20, 8'd30, 2'b01};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 8'd10, 8'd20, 8'd30, 8'd12, 8'd20, 8'd30, 2'b10};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 8'd10, 8'd20, 8'd30, 8'd12, 8'd19, 8'd30, 2'b10};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8'd10, 8'd20, 8'd30, 8'd12, 8'd19, 8'd30, 2'b11};
    // Wraps, collisions and seeding
    vt[6]  = '{1'b1, 1'b0, 1'b0, 8'd23, 8'd0,  8'd59, 8'd23, 8'd0,  8'd59, 2'b01};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 8'd23, 8'd0,  8'd59, 8'd0,  8'd0,  8'd59, 2'b01};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 8'd23, 8'd0,  8'd59, 8'd23, 8'd0,  8'd59, 2'b01};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 8'd23, 8'd0,  8'd59, 8'd23, 8'd0,  8'd59, 2'b01};
    vt[10] = '{1'b1, 1'b1, 1'b0, 8'd23, 8'd0,  8'd59, 8'd23, 8'd0,  8'd59, 2'b10};
    vt[11] = '{1'b0, 1'b0, 1'b1, 8'd23, 8'd0,  8'd59, 8'd23, 8'd59, 8'd59, 2'b10};
    vt[12] = '{1'b1, 1'b0, 1'b0, 8'd23, 8'd0,  8'd59, 8'd23, 8'd59, 8'd59, 2'b11};
    vt[13] = '{1'b0, 1'b1, 1'b0, 8'd23, 8'd0,  8'd59, 8'd23, 8'd59, 8'd0,  2'b11};
    vt[14] = '{1'b1, 1'b0, 1'b0, 8'd23, 8'd0,  8'd59, 8'd23, 8'd59, 8'd0,  2'b00};
    vt[15] = '{1'b0, 1'b1, 1'b0, 8'd23, 8'd0,  8'd59, 8'd23, 8'd59, 8'd0,  2'b00};
    vt[16] = '{1'b1, 1'b0, 1'b0, 8'd30, 8'd75, 8'd80, 8'd0,  8'd0,  8'd0,  2'b01};
    vt[17] = '{1'b1, 1'b0, 1'b1, 8'd30, 8'd75, 8'd80, 8'd0,  8'd0,  8'd0,  2'b10};
    vt[18] = '{1'b1, 1'b0, 1'b0, 8'd30, 8'd75, 8'd80, 8'd0,  8'd0,  8'd0,  2'b11};
    vt[19] = '{1'b1, 1'b0, 1'b0, 8'd30, 8'd75, 8'd80, 8'd0,  8'd0,  8'd0,  2'b00};

    // Reset for two cycles with buttons toggling
    reset = 1'b1;
    cur_hours = 8'd7; cur_minutes = 8'd8; cur_seconds = 8'd9;
    btn_mode = 1'($urandom_range(0, 1)); btn_up = 1'($urandom_range(0, 1));
    btn_down = 1'($urandom_range(0, 1));
    tick(1);
    btn_mode = ~btn_mode; btn_up = ~btn_up; btn_down = ~btn_down;
    tick(1);
    reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset.state", state_dbg, 0);
    tick(12);
    check_all("post_reset_idle", 0, 0, 0, 0, 0);

    // Full edit, then count the load window
    for (int i = 0; i <= 5; i++) run_vec(i);
    btn_mode = 1'b1;
    lcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 8) btn_mode = 1'b0;
      tick(1);
      if (load === 1'b1) begin
        lcnt++;
        check_all("load_window", 12, 19, 30, 0, 1);
      end
    end
    check("load_cycles", lcnt, HOLD);
    check_all("after_load", 12, 19, 30, 0, 0);

    // Wraps, collisions, ignored RUN presses, out-of-range seeding
    for (int i = 6; i <= 19; i++) run_vec(i);

    // Bouncing up press in SET_HR from 5
    do_reset();
    cur_hours = 8'd5; cur_minutes = 8'd1; cur_seconds = 8'd2;
    press(1'b1, 1'b0, 1'b0);
    check_all("bounce_setup", 5, 1, 2, 1, 0);
    btn_up = 1'b1; tick(3);
    btn_up = 1'b0; tick(1);
    btn_up = 1'b1; tick(10);
    btn_up = 1'b0; tick(10);
    check_all("bounce", 6, 1, 2, 1, 0);

    // Reset in the middle of LOAD, with mode held through reset
    do_reset();
    cur_hours = 8'd10; cur_minutes = 8'd20; cur_seconds = 8'd30;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check_all("midload_setup", 10, 20, 30, 3, 0);
    btn_mode = 1'b1;
    lcnt = 0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick(1);
      if (load === 1'b1) begin
        lcnt++;
        if (lcnt == 4) begin
          reset = 1'b1;
          got = 1'b1;
        end
      end
    end
    check("midload_reached", got, 1);
    tick(1);
    reset = 1'b0;
    check_all("midload_reset", 0, 0, 0, 0, 0);
    tick(3);
    check("held_early.mode", mode, 0);
    tick(10);
    check_all("held_through_reset", 10, 20, 30, 1, 0);
    btn_mode = 1'b0;
    tick(10);

    // Randomized presses against a field-level model
    do_reset();
    st = 0; h = 0; mi = 0; s = 0;
    for (int n = 0; n < 80; n++) begin
      m = ($urandom_range(0, 9) < 3);
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      ch = 8'($urandom_range(0, 40));
      cm = 8'($urandom_range(0, 80));
      cs = 8'($urandom_range(0, 80));
      cur_hours = ch; cur_minutes = cm; cur_seconds = cs;
      press(m, u, d);
      if (st == 0) begin
        if (m) begin
          h  = (ch > 23) ? 0 : int'(ch);
          mi = (cm > 59) ? 0 : int'(cm);
          s  = (cs > 59) ? 0 : int'(cs);
          st = 1;
        end
      end else if (m) begin
        st = (st == 3) ? 0 : st + 1;
      end else if (u != d) begin
        case (st)
          1: h  = u ? (h + 1) % 24  : (h + 23) % 24;
          2: mi = u ? (mi + 1) % 60 : (mi + 59) % 60;
          default: s = u ? (s + 1) % 60 : (s + 59) % 60;
        endcase
      end
      check_all($sformatf("rand%0d", n), h, mi, s, st, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
